// File: rtl/reg_file_cb.sv
`timescale 1ns/1ps
// reg_file_cb
// Architectural register file ($r0-$r7) plus condition-bit (CB) register for
// the 8-bit datapath. Two combinational read ports feed the ALU operands.
// One write port takes the ALU/memory result. CB latches either the ALU set
// flag (slt) or the zero flag (seq).
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   rs_addr_i / rs_o            read port A (to ALU rs)
//   rt_addr_i / rt_o            read port B (to ALU rt)
//   wr_en_i, wr_addr_i,
//   wr_data_i                   register write port
//   cb_we_i, cb_sel_i,
//   set_i, zero_i               CB update: cb <= cb_sel_i ? zero_i : set_i
//   cb_o                        registered condition bit
//   r7_o                        current $r7 contents, with write-through
module reg_file_cb #(
    parameter int WIDTH = 8,
    parameter int NREGS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       rs_addr_i,
    input  logic [2:0]       rt_addr_i,
    output logic [WIDTH-1:0] rs_o,
    output logic [WIDTH-1:0] rt_o,
    input  logic             wr_en_i,
    input  logic [2:0]       wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             cb_we_i,
    input  logic             cb_sel_i,
    input  logic             set_i,
    input  logic             zero_i,
    output logic             cb_o,
    output logic [WIDTH-1:0] r7_o
);

    // Flop-based storage. Every register is writable, including $r0.
    logic [WIDTH-1:0] regs_reg [NREGS];
    logic             cb_reg;

    // The write port is inactive while reset is held. This also suppresses
    // the bypass, so that all read ports show 0x00 during reset.
    logic wr_live;
    assign wr_live = wr_en_i && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_en_i) begin
            regs_reg[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cb_reg <= 1'b0;
        end else if (cb_we_i) begin
            cb_reg <= cb_sel_i ? zero_i : set_i;
        end
    end

    // Write-through bypass. A read of the address being written returns the
    // incoming data in the same cycle. Each port is bypassed independently.
    logic bypass_rs;
    logic bypass_rt;
    logic bypass_r7;

    assign bypass_rs = wr_live && (wr_addr_i == rs_addr_i);
    assign bypass_rt = wr_live && (wr_addr_i == rt_addr_i);
    assign bypass_r7 = wr_live && (wr_addr_i == 3'd7);

    assign rs_o = bypass_rs ? wr_data_i : regs_reg[rs_addr_i];
    assign rt_o = bypass_rt ? wr_data_i : regs_reg[rt_addr_i];
    assign r7_o = bypass_r7 ? wr_data_i : regs_reg[7];
    assign cb_o = cb_reg;

endmodule

// File: tb/tb_reg_file_cb.sv
`timescale 1ns/1ps
module tb_reg_file_cb;

    logic       clk;
    logic       reset;
    logic [2:0] rs_addr_i;
    logic [2:0] rt_addr_i;
    logic [7:0] rs_o;
    logic [7:0] rt_o;
    logic       wr_en_i;
    logic [2:0] wr_addr_i;
    logic [7:0] wr_data_i;
    logic       cb_we_i;
    logic       cb_sel_i;
    logic       set_i;
    logic       zero_i;
    logic       cb_o;
    logic [7:0] r7_o;

    int errors = 0;
    int checks = 0;

    // Reference model: the architectural state as the specification describes it
    logic [7:0] model_regs [8];
    logic       model_cb;

    reg_file_cb #(.WIDTH(8), .NREGS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .rs_addr_i (rs_addr_i),
        .rt_addr_i (rt_addr_i),
        .rs_o      (rs_o),
        .rt_o      (rt_o),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .cb_we_i   (cb_we_i),
        .cb_sel_i  (cb_sel_i),
        .set_i     (set_i),
        .zero_i    (zero_i),
        .cb_o      (cb_o),
        .r7_o      (r7_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value a read port must show for address a, given the current inputs
    function automatic logic [7:0] exp_read(input logic [2:0] a);
        if (reset) return 8'h00;
        if (wr_en_i && wr_addr_i == a) return wr_data_i;
        return model_regs[a];
    endfunction

    function automatic logic exp_cb();
        return reset ? 1'b0 : model_cb;
    endfunction

    // Advance one rising edge; the model applies the rules to the held inputs
    task automatic tick();
        if (reset) begin
            for (int i = 0; i < 8; i++) model_regs[i] = 8'h00;
            model_cb = 1'b0;
        end else begin
            if (wr_en_i) model_regs[wr_addr_i] = wr_data_i;
            if (cb_we_i) model_cb = cb_sel_i ? zero_i : set_i;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en_i = 1'b0; wr_addr_i = 3'd0; wr_data_i = 8'h00;
        cb_we_i = 1'b0; cb_sel_i = 1'b0; set_i = 1'b0; zero_i = 1'b0;
        rs_addr_i = 3'd0; rt_addr_i = 3'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        for (int i = 0; i < 8; i++) model_regs[i] = 8'h00;
        model_cb = 1'b0;
        tick();
        // Random writes and CB updates under reset must be ignored
        for (int c = 0; c < 8; c++) begin
            wr_en_i = 1'b1; wr_addr_i = 3'(c); wr_data_i = 8'($urandom_range(1, 255));
            cb_we_i = 1'b1; cb_sel_i = 1'($urandom); set_i = 1'b1; zero_i = 1'b1;
            rs_addr_i = 3'(c); rt_addr_i = 3'(c);
            #1;
            checks++;
            if (rs_o !== 8'h00 || rt_o !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold_read addr=%0d rs=%h rt=%h required 00", c, rs_o, rt_o);
            end
            checks++;
            if (cb_o !== 1'b0 || r7_o !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold_cb_r7 cb=%b r7=%h required 0/00", cb_o, r7_o);
            end
            tick();
        end
        idle_inputs();
        reset = 1'b0;
        tick();
        for (int a = 0; a < 8; a++) begin
            rs_addr_i = 3'(a); rt_addr_i = 3'(7 - a);
            #1;
            checks++;
            if (rs_o !== 8'h00 || rt_o !== 8'h00) begin
                errors++;
                $display("FAIL reset_release_read addr=%0d rs=%h rt=%h required 00", a, rs_o, rt_o);
            end
        end
        checks++;
        if (cb_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_cb cb=%b required 0", cb_o);
        end
        $display("test_reset done");
    endtask

    task automatic test_write_read();
        for (int n = 0; n < 8; n++) begin
            wr_en_i = 1'b1; wr_addr_i = 3'(n); wr_data_i = 8'(8'h11 * n);
            $display("write r%0d <= %h", n, wr_data_i);
            tick();
        end
        wr_en_i = 1'b0;
        #1;
        checks++;
        if (r7_o !== 8'h77) begin
            errors++;
            $display("FAIL write_read_r7 r7=%h required 77", r7_o);
        end
        for (int a = 0; a < 8; a++) begin
            rs_addr_i = 3'(a); rt_addr_i = 3'(7 - a);
            #1;
            checks++;
            if (rs_o !== 8'(8'h11 * a) || rt_o !== 8'(8'h11 * (7 - a))) begin
                errors++;
                $display("FAIL write_read_sweep a=%0d rs=%h rt=%h required %h %h",
                         a, rs_o, rt_o, 8'(8'h11 * a), 8'(8'h11 * (7 - a)));
            end
        end
        $display("test_write_read done");
    endtask

    task automatic test_bypass();
        wr_en_i = 1'b1; wr_addr_i = 3'd3; wr_data_i = 8'h40;
        tick();
        wr_data_i = 8'hA5;
        rs_addr_i = 3'd3; rt_addr_i = 3'd3;
        #1;
        checks++;
        if (rs_o !== 8'hA5 || rt_o !== 8'hA5) begin
            errors++;
            $display("FAIL bypass_same_cycle rs=%h rt=%h required a5", rs_o, rt_o);
        end
        tick();
        wr_en_i = 1'b0; wr_data_i = 8'h00;
        #1;
        checks++;
        if (rs_o !== 8'hA5 || rt_o !== 8'hA5) begin
            errors++;
            $display("FAIL bypass_after_edge rs=%h rt=%h required a5", rs_o, rt_o);
        end
        // r7 bypass
        wr_en_i = 1'b1; wr_addr_i = 3'd7; wr_data_i = 8'h5A;
        #1;
        checks++;
        if (r7_o !== 8'h5A) begin
            errors++;
            $display("FAIL bypass_r7 r7=%h required 5a", r7_o);
        end
        tick();
        wr_en_i = 1'b0;
        $display("test_bypass done");
    endtask

    task automatic test_cb();
        set_i = 1'b1; zero_i = 1'b0;
        cb_we_i = 1'b1; cb_sel_i = 1'b0;
        tick();
        checks++;
        if (cb_o !== 1'b1) begin
            errors++;
            $display("FAIL cb_sel_set cb=%b required 1", cb_o);
        end
        cb_sel_i = 1'b1;
        tick();
        checks++;
        if (cb_o !== 1'b0) begin
            errors++;
            $display("FAIL cb_sel_zero cb=%b required 0", cb_o);
        end
        // Load a 1, then disable updates with flags that would select 0
        cb_sel_i = 1'b0;
        tick();
        cb_we_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            set_i = 1'b0; zero_i = 1'b0; cb_sel_i = 1'(c);
            tick();
            checks++;
            if (cb_o !== 1'b1) begin
                errors++;
                $display("FAIL cb_hold cycle=%0d cb=%b required 1", c, cb_o);
            end
        end
        $display("test_cb done");
    endtask

    task automatic test_simultaneous();
        wr_en_i = 1'b1; wr_addr_i = 3'd5; wr_data_i = 8'h3C;
        cb_we_i = 1'b1; cb_sel_i = 1'b1; zero_i = 1'b1; set_i = 1'b0;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (cb_o !== 1'b1) begin
            errors++;
            $display("FAIL simul_cb cb=%b required 1", cb_o);
        end
        for (int a = 0; a < 8; a++) begin
            rs_addr_i = 3'(a);
            #1;
            checks++;
            if (rs_o !== model_regs[a]) begin
                errors++;
                $display("FAIL simul_regs r%0d=%h required %h", a, rs_o, model_regs[a]);
            end
        end
        checks++;
        if (model_regs[5] !== 8'h3C) begin
            errors++;
            $display("FAIL simul_model r5=%h required 3c", model_regs[5]);
        end
        $display("test_simultaneous done");
    endtask

    task automatic test_async_reset();
        for (int n = 0; n < 8; n++) begin
            wr_en_i = 1'b1; wr_addr_i = 3'(n); wr_data_i = 8'($urandom_range(1, 255));
            cb_we_i = 1'b1; cb_sel_i = 1'b0; set_i = 1'b1;
            tick();
        end
        idle_inputs();
        rs_addr_i = 3'd2; rt_addr_i = 3'd6;
        #1;
        checks++;
        if (cb_o !== 1'b1 || rs_o !== model_regs[2] || r7_o !== model_regs[7]) begin
            errors++;
            $display("FAIL async_preload cb=%b rs=%h r7=%h required 1 %h %h",
                     cb_o, rs_o, r7_o, model_regs[2], model_regs[7]);
        end
        // Assert reset between edges; outputs must clear without a clock edge
        #1;
        reset = 1'b1;
        for (int i = 0; i < 8; i++) model_regs[i] = 8'h00;
        model_cb = 1'b0;
        #1;
        checks++;
        if (rs_o !== 8'h00 || rt_o !== 8'h00 || r7_o !== 8'h00 || cb_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset rs=%h rt=%h r7=%h cb=%b required 00 00 00 0",
                     rs_o, rt_o, r7_o, cb_o);
        end
        tick();
        reset = 1'b0;
        tick();
        for (int a = 0; a < 8; a++) begin
            rs_addr_i = 3'(a);
            #1;
            checks++;
            if (rs_o !== 8'h00) begin
                errors++;
                $display("FAIL async_reset_after r%0d=%h required 00", a, rs_o);
            end
        end
        $display("test_async_reset done");
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            reset     = ($urandom_range(0, 39) == 0);
            wr_en_i   = 1'($urandom);
            wr_addr_i = 3'($urandom);
            wr_data_i = 8'($urandom);
            cb_we_i   = 1'($urandom);
            cb_sel_i  = 1'($urandom);
            set_i     = 1'($urandom);
            zero_i    = 1'($urandom);
            rs_addr_i = ($urandom_range(0, 3) == 0) ? wr_addr_i : 3'($urandom);
            rt_addr_i = ($urandom_range(0, 3) == 0) ? wr_addr_i : 3'($urandom);
            if (reset) begin
                for (int i = 0; i < 8; i++) model_regs[i] = 8'h00;
                model_cb = 1'b0;
            end
            #1;
            $display("txn %0d rst=%b we=%b wa=%0d wd=%h rs_a=%0d rt_a=%0d rs=%h rt=%h r7=%h cb=%b",
                     c, reset, wr_en_i, wr_addr_i, wr_data_i, rs_addr_i, rt_addr_i,
                     rs_o, rt_o, r7_o, cb_o);
            checks++;
            if (rs_o !== exp_read(rs_addr_i) || rt_o !== exp_read(rt_addr_i)) begin
                errors++;
                $display("FAIL random_ports txn=%0d rs=%h rt=%h required %h %h",
                         c, rs_o, rt_o, exp_read(rs_addr_i), exp_read(rt_addr_i));
            end
            checks++;
            if (r7_o !== exp_read(3'd7) || cb_o !== exp_cb()) begin
                errors++;
                $display("FAIL random_r7_cb txn=%0d r7=%h cb=%b required %h %b",
                         c, r7_o, cb_o, exp_read(3'd7), exp_cb());
            end
            tick();
        end
        reset = 1'b0;
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_cb();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
